// File: rtl/gpio_seq.sv
// gpio_seq: plays a CPU-loaded table of (gpio word, hold delay) steps onto a gpio data register.
// Optional done interrupt enabled by defining GPIO_SEQ_IRQ_EN.
module gpio_seq #(
    parameter int num_gpio = 32,
    parameter int depth    = 16,
    parameter int dly_w    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stb,
    input  logic                we,
    input  logic [1:0]          addr,
    input  logic [31:0]         data_in,
    output logic [31:0]         data_out,
    output logic                ack,
    output logic                g_stb,
    output logic                g_we,
    output logic                g_addr,
    output logic [num_gpio-1:0] g_data,
    input  logic                g_ack,
    output logic                irq
);

    localparam int sw = $clog2(depth);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [sw-1:0]       step_q, step_d;
    logic [dly_w-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                stop_pend_q, stop_pend_d;
    logic                loop_q;
    logic [7:0]          len_q;
    logic [sw-1:0]       wptr_q;
    logic [num_gpio-1:0] g_data_q;
    logic [dly_w-1:0]    dly_q;
    logic                fetch;

    logic [num_gpio-1:0] table_data [depth];
    logic [dly_w-1:0]    table_dly  [depth];

    logic        ctrl_wr, start_req, stop_req, clr_done;
    logic        wptr_wr, tdata_wr, tdly_wr;
    logic [8:0]  len_raw;
    logic [7:0]  len_new;
    logic [7:0]  step_ext;
    logic        last_step;
    logic        busy;
    logic        irq_en;
    logic [31:0] status;

    assign ctrl_wr   = stb & we & (addr == 2'd0);
    assign wptr_wr   = stb & we & (addr == 2'd1);
    assign tdata_wr  = stb & we & (addr == 2'd2);
    assign tdly_wr   = stb & we & (addr == 2'd3);
    // A simultaneous stop masks the start so stop always wins.
    assign start_req = ctrl_wr & data_in[0] & ~data_in[1];
    assign stop_req  = ctrl_wr & data_in[1];
    assign clr_done  = ctrl_wr & data_in[3];

    assign len_raw   = {1'b0, data_in[15:8]};
    assign len_new   = (len_raw > 9'(depth)) ? 8'(depth) : data_in[15:8];
    assign step_ext  = 8'(step_q);
    assign last_step = (step_ext == len_q - 8'd1);
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        stop_pend_d = stop_pend_q;
        fetch       = 1'b0;
        if (clr_done) begin
            done_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (start_req && (len_new != 8'd0)) begin
                    done_d  = 1'b0;
                    step_d  = '0;
                    fetch   = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // A stop seen mid-transaction waits for the ack so the gpio write completes.
                if (g_ack) begin
                    if (stop_pend_q || stop_req) begin
                        stop_pend_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        cnt_d   = dly_q;
                        state_d = S_HOLD;
                    end
                end else if (stop_req) begin
                    stop_pend_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (stop_req) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - dly_w'(1);
                end else if (last_step) begin
                    if (loop_q) begin
                        step_d  = '0;
                        fetch   = 1'b1;
                        state_d = S_WRITE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    step_d  = step_q + sw'(1);
                    fetch   = 1'b1;
                    state_d = S_WRITE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            loop_q      <= 1'b0;
            len_q       <= '0;
            wptr_q      <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
            // loop and len track every CTRL write, even while a run is active.
            if (ctrl_wr) begin
                loop_q <= data_in[2];
                len_q  <= len_new;
            end
            if (wptr_wr) begin
                wptr_q <= data_in[sw-1:0];
            end else if (tdly_wr) begin
                wptr_q <= wptr_q + sw'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tdata_wr) begin
            table_data[wptr_q] <= data_in[num_gpio-1:0];
        end
        if (tdly_wr) begin
            table_dly[wptr_q] <= data_in[dly_w-1:0];
        end
    end

    // The step is fetched as WRITE is entered, so the word is valid for the whole strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_data_q <= '0;
        end else if (fetch) begin
            g_data_q <= table_data[step_d];
        end
    end

    always_ff @(posedge clk) begin
        if (fetch) begin
            dly_q <= table_dly[step_d];
        end
    end

`ifdef GPIO_SEQ_IRQ_EN
    logic irq_en_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
        end else if (ctrl_wr) begin
            irq_en_q <= data_in[4];
        end
    end
    assign irq_en = irq_en_q;
    assign irq    = done_q & irq_en_q;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        status        = 32'd0;
        status[0]     = busy;
        status[1]     = done_q;
        status[2]     = loop_q;
        status[4]     = irq_en;
        status[15:8]  = len_q;
        status[23:16] = step_ext;
    end

    always_comb begin
        data_out = 32'd0;
        if (stb && !we) begin
            case (addr)
                2'd0:    data_out = status;
                2'd1:    data_out = 32'(wptr_q);
                default: data_out = 32'd0;
            endcase
        end
    end

    assign ack    = stb;
    assign g_stb  = (state_q == S_WRITE);
    assign g_we   = g_stb;
    assign g_addr = 1'b0;
    assign g_data = g_data_q;

endmodule

// File: tb/tb_gpio_seq.sv
// Bench for gpio_seq: schedule-based model of expected gpio writes, per-cycle compare, random runs.
`timescale 1ns/1ps
module tb_gpio_seq;

    localparam int NG    = 32;
    localparam int DEPTH = 16;
    localparam int DW    = 16;
    localparam int BIG   = 32'h7fffffff;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, we;
    logic [1:0]  addr;
    logic [31:0] data_in, data_out;
    logic        ack, g_stb, g_we, g_addr, g_ack, irq;
    logic [31:0] g_data;

    always #5 clk = ~clk;

    gpio_seq #(.num_gpio(NG), .depth(DEPTH), .dly_w(DW)) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .ack(ack),
        .g_stb(g_stb), .g_we(g_we), .g_addr(g_addr), .g_data(g_data),
        .g_ack(g_ack), .irq(irq)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic chk_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // gpio peripheral: acks after the strobe has been high for ack_lat cycles
    int ack_lat = 0;
    int hi_cnt  = 0;
    assign g_ack = g_stb && (hi_cnt == ack_lat);
    always @(posedge clk) begin
        if (g_stb && !g_ack) hi_cnt <= hi_cnt + 1;
        else hi_cnt <= 0;
    end

    // Model: each expected gpio write occupies cycles s..e (strobe) then hold up to hend.
    typedef struct {
        int s;
        int e;
        int hend;
        int step;
        logic [31:0] data;
    } wr_t;

    wr_t         sched[$];
    logic [31:0] tbl_data [DEPTH];
    int          tbl_dly  [DEPTH];
    int          wptr_m    = 0;
    int          len_m     = 0;
    int          loop_m    = 0;
    int          irq_en_m  = 0;
    int          run_start = 0;
    int          run_end   = 0;
    int          done_at   = BIG;

    int rises[$];
    int lens[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void build(input int t0);
        int t;
        int st;
        wr_t w;
        t  = t0;
        st = 0;
        sched.delete();
        run_start = t0;
        while (1) begin
            w.s    = t;
            w.e    = t + ack_lat;
            w.hend = t + ack_lat + 1 + tbl_dly[st];
            w.step = st;
            w.data = tbl_data[st];
            sched.push_back(w);
            t  = w.hend + 1;
            st = st + 1;
            if (st == len_m) begin
                if (loop_m != 0) st = 0;
                else break;
            end
            if (t > t0 + 600) break;
        end
        run_end = (loop_m != 0) ? BIG : t;
        done_at = (loop_m != 0) ? BIG : t;
    endfunction

    function automatic void apply_stop(input int s);
        if (s < run_start || s >= run_end) return;
        for (int k = 0; k < sched.size(); k++) begin
            if (s >= sched[k].s && s <= sched[k].hend) begin
                run_end = (s <= sched[k].e) ? sched[k].e + 1 : s + 1;
                while (sched.size() > k + 1) void'(sched.pop_back());
                done_at = BIG;
                return;
            end
        end
    endfunction

    function automatic int cur_step(input int c);
        int r;
        r = 0;
        foreach (sched[k]) if (sched[k].s <= c) r = sched[k].step;
        return r;
    endfunction

    function automatic logic [31:0] exp_status(input int c);
        logic [31:0] v;
        int st;
        v  = 32'd0;
        st = cur_step(c);
        v[0] = (c >= run_start) && (c < run_end);
        v[1] = (c >= done_at);
        v[2] = (loop_m != 0);
`ifdef GPIO_SEQ_IRQ_EN
        v[4] = (irq_en_m != 0);
`endif
        v[15:8]  = len_m[7:0];
        v[23:16] = st[7:0];
        return v;
    endfunction

    function automatic logic exp_irq(input int c);
        return (c >= done_at) && (irq_en_m != 0);
    endfunction

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int c);
        @(negedge clk);
        stb = 1'b1; we = w; addr = a; data_in = d;
        c = cyc;
        #1;
        rd = data_out;
        check("ack", {31'd0, ack}, 32'd1);
        @(posedge clk);
        #1;
        stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'd0;
    endtask

    task automatic ctrl(input int st, input int sp, input int lp, input int lv,
                        input int clr, input int ien, output int c);
        logic [31:0] d, rd;
        logic busy_m;
        d = 32'd0;
        d[0] = st[0]; d[1] = sp[0]; d[2] = lp[0]; d[3] = clr[0]; d[4] = ien[0];
        d[15:8] = lv[7:0];
        bus(1'b1, 2'd0, d, rd, c);
        busy_m = (c >= run_start) && (c < run_end);
        len_m  = (lv > DEPTH) ? DEPTH : lv;
        loop_m = lp;
`ifdef GPIO_SEQ_IRQ_EN
        irq_en_m = ien;
`endif
        if (clr != 0 && done_at <= c) done_at = BIG;
        if (sp != 0) apply_stop(c);
        else if (st != 0 && !busy_m && len_m != 0) build(c + 1);
        $display("ctrl @%0d start=%0d stop=%0d loop=%0d len=%0d clr=%0d lat=%0d busy=%0d",
                 c, st, sp, lp, lv, clr, ack_lat, busy_m);
    endtask

    task automatic load(input int idx, input logic [31:0] dv, input int dl);
        logic [31:0] rd;
        int c;
        bus(1'b1, 2'd1, idx, rd, c);
        wptr_m = idx;
        bus(1'b1, 2'd2, dv, rd, c);
        tbl_data[wptr_m] = dv;
        bus(1'b1, 2'd3, dl, rd, c);
        tbl_dly[wptr_m] = dl;
        wptr_m = (wptr_m + 1) % DEPTH;
    endtask

    task automatic read_status(input string nm, output logic [31:0] rd);
        int c;
        bus(1'b0, 2'd0, 32'd0, rd, c);
        check(nm, rd, exp_status(c));
    endtask

    task automatic wait_until(input int t);
        int guard;
        guard = 0;
        while (cyc < t && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (cyc <= run_end && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 5000) begin
            n_assert++;
            n_fail++;
            $display("FAIL wait_idle: no end of run within 5000 cycles (cycle %0d)", cyc);
        end
    endtask

    // per-cycle comparison of the gpio port, idle read bus and irq against the model
    initial begin : compare
        int c;
        logic es;
        logic [31:0] ed;
        logic prev;
        int hi_run;
        prev = 1'b0;
        hi_run = 0;
        wait (chk_on);
        forever begin
            @(posedge clk); #4;
            c  = cyc;
            es = 1'b0;
            ed = 32'd0;
            foreach (sched[k]) if (c >= sched[k].s && c <= sched[k].e) begin
                es = 1'b1;
                ed = sched[k].data;
            end
            check("g_stb", {31'd0, g_stb}, {31'd0, es});
            if (es && g_stb) begin
                check("g_data", g_data, ed);
                check("g_we", {31'd0, g_we}, 32'd1);
                check("g_addr", {31'd0, g_addr}, 32'd0);
            end
            check("data_out_idle", data_out, 32'd0);
            check("irq", {31'd0, irq}, {31'd0, exp_irq(c)});
            if (g_stb && !prev) rises.push_back(c);
            if (g_stb) hi_run++;
            else if (prev) begin
                lens.push_back(hi_run);
                hi_run = 0;
            end
            prev = g_stb;
        end
    end

    initial begin : main
        logic [31:0] rd;
        int c, t, n, lv, lp, ien;
        stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'd0;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1'b1;

        // reset state
        bus(1'b0, 2'd0, 32'd0, rd, c);
        check("status_reset", rd, 32'd0);
        bus(1'b0, 2'd1, 32'd0, rd, c);
        check("wptr_reset", rd, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("no_strobe_after_reset", rises.size(), 0);

        // fill the whole table starting at 14 so WPTR wraps
        bus(1'b1, 2'd1, 32'd14, rd, c);
        wptr_m = 14;
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] dv;
            int dl;
            dv = $urandom;
            dl = $urandom_range(0, 6);
            bus(1'b1, 2'd2, dv, rd, c);
            tbl_data[wptr_m] = dv;
            bus(1'b1, 2'd3, dl, rd, c);
            tbl_dly[wptr_m] = dl;
            wptr_m = (wptr_m + 1) % DEPTH;
        end
        bus(1'b0, 2'd1, 32'd0, rd, c);
        check("wptr_wrap", rd, 32'd14);

        // one-shot two-step pattern
        load(0, 32'h000000A5, 3);
        load(1, 32'h0000005A, 0);
        rises.delete();
        ctrl(1, 0, 0, 2, 0, 1, c);
        check("model_oneshot_len", run_end - run_start, 7);
        wait_idle();
        check("oneshot_writes", rises.size(), 2);
        check("oneshot_first", rises[0], c + 1);
        check("oneshot_gap", rises[1] - rises[0], 5);
        read_status("status_oneshot", rd);
`ifdef GPIO_SEQ_IRQ_EN
        check("status_oneshot_lit", rd, 32'h0001_0212);
        check("irq_with_done", {31'd0, irq}, 32'd1);
        ctrl(0, 0, 0, 2, 1, 1, c);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        read_status("status_cleared", rd);
        check("status_cleared_lit", rd, 32'h0001_0210);
        ctrl(0, 0, 0, 2, 0, 0, c);
`else
        check("status_oneshot_lit", rd, 32'h0001_0202);
        check("irq_tied_low", {31'd0, irq}, 32'd0);
        ctrl(0, 0, 0, 2, 1, 0, c);
        read_status("status_cleared", rd);
        check("status_cleared_lit", rd, 32'h0001_0200);
`endif

        // looping run, then stop during a step-0 hold
        rises.delete();
        ctrl(1, 0, 1, 2, 0, 0, c);
        wait_until(run_start + 16);
        check("loop_period_a", rises[2] - rises[0], 7);
        check("loop_period_b", rises[3] - rises[1], 7);
        t = 0;
        foreach (sched[k]) if (t == 0 && sched[k].step == 0 && sched[k].e >= cyc + 1) t = sched[k].e + 2;
        wait_until(t);
        ctrl(0, 1, 1, 2, 0, 0, c);
        check("model_stop_hold", run_end, c + 1);
        n = rises.size();
        repeat (20) @(posedge clk);
        #1;
        check("no_writes_after_stop", rises.size(), n);
        read_status("status_stop_hold", rd);
        check("status_stop_hold_lit", rd, 32'h0000_0204);

        // slow gpio, stop raised during WRITE
        ack_lat = 4;
        lens.delete();
        ctrl(1, 0, 0, 2, 0, 0, c);
        wait_until(run_start + 1);
        ctrl(0, 1, 0, 2, 0, 0, c);
        wait_idle();
        repeat (10) @(posedge clk);
        #1;
        check("stop_write_count", lens.size(), 1);
        check("stop_write_held", lens[0], 5);
        read_status("status_stop_write", rd);
        check("status_stop_write_lit", rd, 32'h0000_0200);
        ack_lat = 0;

        // len=0 start and start+stop while idle are both ignored
        ctrl(1, 0, 0, 0, 0, 0, c);
        read_status("status_len0", rd);
        check("status_len0_lit", rd, 32'h0000_0000);
        ctrl(1, 1, 0, 2, 0, 0, c);
        read_status("status_start_stop", rd);
        check("status_start_stop_lit", rd, 32'h0000_0200);

        // start while busy leaves the run untouched
        rises.delete();
        ctrl(1, 0, 0, 2, 0, 0, c);
        ctrl(1, 0, 0, 2, 0, 0, c);
        wait_idle();
        check("restart_ignored_writes", rises.size(), 2);

        // over-long len clamps to the table depth
        rises.delete();
        ctrl(1, 0, 0, 20, 0, 0, c);
        wait_idle();
        check("clamp_writes", rises.size(), 16);
        read_status("status_clamp", rd);
        check("status_clamp_lit", rd, 32'h000F_1002);

        // randomized runs
        for (int i = 0; i < 30; i++) begin
            ack_lat = $urandom_range(0, 3);
            repeat ($urandom_range(1, 4)) load($urandom_range(0, DEPTH - 1), $urandom, $urandom_range(0, 6));
            lv  = $urandom_range(1, 20);
            lp  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            ien = $urandom_range(0, 1);
            ctrl(1, 0, lp, lv, 0, ien, c);
            if ($urandom_range(0, 1) == 1) begin
                if (lp != 0) t = run_start + $urandom_range(0, 30);
                else t = run_start + $urandom_range(0, run_end - 2 - run_start);
                wait_until(t);
                ctrl(1, 0, lp, lv, 0, ien, c);
            end
            if (lp != 0 || $urandom_range(0, 2) == 0) begin
                wait_until(cyc + $urandom_range(0, 60));
                ctrl($urandom_range(0, 1), 1, lp, lv, 0, ien, c);
            end
            wait_idle();
            read_status("status_run", rd);
            if ($urandom_range(0, 2) == 0) begin
                ctrl(0, 0, lp, lv, 1, ien, c);
                read_status("status_clr", rd);
            end
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
